ball_motion_ctrl: RTL and testbench

- Drives the ball's position for the bounce-ball game and consumes the paddle-collision result.
- The collision block toggles a hit flag each time the ball meets the paddle. This block detects that toggle, reflects the ball vertically, bounces it off the screen walls, and handles serve and miss sequencing.
- Its outputs ball_x_reg and ball_y_reg feed the collision block and the pixel generator.

---
 rtl/game_pkg.sv | 20 ++
 rtl/frame_counter.sv | 39 +++
 rtl/ball_motion_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ball_motion_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants for the bounce-ball game: screen geometry, ball size and
// the play-state encoding used by the motion, collision and pixel blocks.
package game_pkg;

  localparam int H_RES     = 640;  // visible width in pixels
  localparam int V_RES     = 480;  // visible height in pixels
  localparam int BALL_SIZE = 8;    // ball edge length in pixels

  // Largest legal top-left corner that keeps the whole ball on screen.
  localparam int X_MAX = H_RES - BALL_SIZE;
  localparam int Y_MAX = V_RES - BALL_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_MOVE  = 2'd2,
    ST_MISS  = 2'd3
  } game_state_t;

endpackage

// File: rtl/frame_counter.sv
// Counts frame_tick pulses while enabled and flags the tick that completes
// COUNT frames. Used to time both the serve wait and the miss wait.
//   clk, rst    : clock, asynchronous active-high reset
//   en          : count frame ticks while high
//   clr         : synchronous clear (wins over en)
//   frame_tick  : one-cycle pulse per video frame
//   done        : high in the cycle of the COUNT-th tick (combinational)
module frame_counter #(
  parameter int COUNT = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic frame_tick,
  output logic done
);

  localparam int W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [W-1:0] LAST = W'(COUNT - 1);

  logic [W-1:0] count_q;

  assign done = en && frame_tick && (count_q == LAST);

  // NOTE: sequential state is assigned with <= so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && frame_tick) begin
      // Wrap on the terminal tick so the next user starts from zero.
      count_q <= done ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Ball position controller: serve timing, wall bounces, paddle reflection
// (from the collision block's hit toggle) and miss sequencing.
//   clk, rst    : clock, asynchronous active-high reset
//   frame_tick  : one-cycle pulse per video frame; all motion happens on it
//   start_btn   : level, launches play from IDLE
//   hit_toggle  : collision flag, every change of value is one paddle hit
//   ball_x_reg  : ball left edge
//   ball_y_reg  : ball top edge
//   dir_x/dir_y : 1 = right/down, 0 = left/up
//   state       : IDLE=0, SERVE=1, MOVE=2, MISS=3
//   miss_pulse  : one-cycle pulse on entry to MISS
//   miss_count  : saturating miss counter
module ball_motion_ctrl
  import game_pkg::*;
#(
  parameter int BALL_SPEED   = 2,
  parameter int START_X      = 316,
  parameter int START_Y      = 236,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       hit_toggle,
  output logic [9:0] ball_x_reg,
  output logic [9:0] ball_y_reg,
  output logic       dir_x,
  output logic       dir_y,
  output logic [1:0] state,
  output logic       miss_pulse,
  output logic [3:0] miss_count
);

  // Sums are carried at 11 bits so x + speed cannot wrap past 1023.
  localparam logic [10:0] SPEED11  = 11'(BALL_SPEED);
  localparam logic [10:0] X_MAX11  = 11'(X_MAX);
  localparam logic [10:0] Y_MAX11  = 11'(Y_MAX);
  localparam logic [9:0]  X_MAX10  = 10'(X_MAX);
  localparam logic [9:0]  START_X10 = 10'(START_X);
  localparam logic [9:0]  START_Y10 = 10'(START_Y);

  game_state_t state_q;
  logic        hit_prev;
  logic        hit_pend;
  logic        wait_done;

  logic [10:0] x_ext, y_ext;
  logic [9:0]  x_nxt, y_nxt;
  logic        dx_nxt, dy_nxt;
  logic        hit_bottom;

  assign state = state_q;

  // Serve and miss both wait SERVE_FRAMES ticks; the counter idles at zero
  // in the other states so each wait starts from a clean count.
  frame_counter #(
    .COUNT (SERVE_FRAMES)
  ) u_wait (
    .clk        (clk),
    .rst        (rst),
    .en         ((state_q == ST_SERVE) || (state_q == ST_MISS)),
    .clr        ((state_q == ST_IDLE) || (state_q == ST_MOVE)),
    .frame_tick (frame_tick),
    .done       (wait_done)
  );

  // Candidate position for the next frame while in MOVE.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    x_ext      = {1'b0, ball_x_reg};
    y_ext      = {1'b0, ball_y_reg};
    x_nxt      = ball_x_reg;
    y_nxt      = ball_y_reg;
    dx_nxt     = dir_x;
    dy_nxt     = dir_y;
    hit_bottom = 1'b0;

    if (!dir_x && (x_ext < SPEED11)) begin
      x_nxt  = '0;
      dx_nxt = 1'b1;
    end else if (dir_x && (x_ext + SPEED11 > X_MAX11)) begin
      x_nxt  = X_MAX10;
      dx_nxt = 1'b0;
    end else if (dir_x) begin
      x_nxt = 10'(x_ext + SPEED11);
    end else begin
      x_nxt = 10'(x_ext - SPEED11);
    end

    // A pending paddle hit outranks both walls, so a hit on the same frame
    // the ball would cross the bottom edge saves it.
    if (hit_pend) begin
      dy_nxt = 1'b0;
      y_nxt  = (y_ext < SPEED11) ? '0 : 10'(y_ext - SPEED11);
    end else if (!dir_y && (y_ext < SPEED11)) begin
      y_nxt  = '0;
      dy_nxt = 1'b1;
    end else if (dir_y && (y_ext + SPEED11 > Y_MAX11)) begin
      hit_bottom = 1'b1;
    end else if (dir_y) begin
      y_nxt = 10'(y_ext + SPEED11);
    end else begin
      y_nxt = 10'(y_ext - SPEED11);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ball_x_reg <= START_X10;
      ball_y_reg <= START_Y10;
      dir_x      <= 1'b1;
      dir_y      <= 1'b0;
      miss_pulse <= 1'b0;
      miss_count <= '0;
      hit_prev   <= 1'b0;
      hit_pend   <= 1'b0;
    end else begin
      hit_prev   <= hit_toggle;
      miss_pulse <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          hit_pend   <= 1'b0;
          ball_x_reg <= START_X10;
          ball_y_reg <= START_Y10;
          if (start_btn) state_q <= ST_SERVE;
        end

        ST_SERVE: begin
          hit_pend <= 1'b0;
          if (wait_done) begin
            state_q <= ST_MOVE;
            dir_x   <= 1'b1;
            dir_y   <= 1'b0;
          end
        end

        ST_MOVE: begin
          if (frame_tick) begin
            if (hit_bottom) begin
              state_q    <= ST_MISS;
              miss_pulse <= 1'b1;
              if (miss_count != 4'hF) miss_count <= miss_count + 4'd1;
            end else begin
              ball_x_reg <= x_nxt;
              ball_y_reg <= y_nxt;
              dir_x      <= dx_nxt;
              dir_y      <= dy_nxt;
            end
          end
          // A toggle landing on a tick cycle survives the clear and is
          // applied on the following tick.
          if (hit_toggle != hit_prev) hit_pend <= 1'b1;
          else if (frame_tick)        hit_pend <= 1'b0;
        end

        ST_MISS: begin
          hit_pend <= 1'b0;
          if (wait_done) begin
            state_q    <= ST_SERVE;
            ball_x_reg <= START_X10;
            ball_y_reg <= START_Y10;
            dir_x      <= 1'b1;
            dir_y      <= 1'b0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Self-checking bench for ball_motion_ctrl: a frame-level reference model is
// stepped on every clock and compared with the DUT on every falling edge;
// hand-computed positions at chosen frames pin the model.
module tb_ball_motion_ctrl;

  localparam int SX = 316, SY = 236, SPD = 2, FRAMES = 60;
  localparam int XMAX = 632, YMAX = 472;

  logic       clk = 1'b0;
  logic       rst, frame_tick, start_btn, hit_toggle;
  logic [9:0] ball_x_reg, ball_y_reg;
  logic       dir_x, dir_y, miss_pulse;
  logic [1:0] state;
  logic [3:0] miss_count;

  always #5 clk = ~clk;

  ball_motion_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start_btn  (start_btn),
    .hit_toggle (hit_toggle),
    .ball_x_reg (ball_x_reg),
    .ball_y_reg (ball_y_reg),
    .dir_x      (dir_x),
    .dir_y      (dir_y),
    .state      (state),
    .miss_pulse (miss_pulse),
    .miss_count (miss_count)
  );

  int checks = 0;
  int failures = 0;
  int tick_n = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: phase 0..3 = idle/serve/move/miss, frames waited so far.
  int m_phase, m_x, m_y, m_dx, m_dy, m_wait, m_pend, m_prev, m_pulse, m_misses;

  function automatic void model_reset();
    m_phase = 0; m_x = SX; m_y = SY; m_dx = 1; m_dy = 0;
    m_wait = 0; m_pend = 0; m_prev = 0; m_pulse = 0; m_misses = 0;
  endfunction

  function automatic void model_step();
    int toggled, nx, ny, ndx, ndy, missed;
    toggled = (int'(hit_toggle) != m_prev);
    m_prev  = int'(hit_toggle);
    m_pulse = 0;
    case (m_phase)
      0: begin
        m_pend = 0;
        if (start_btn) begin m_phase = 1; m_wait = 0; end
      end
      1: begin
        m_pend = 0;
        if (frame_tick) m_wait++;
        if (m_wait == FRAMES) begin
          m_phase = 2; m_wait = 0; m_dx = 1; m_dy = 0;
        end
      end
      2: begin
        if (frame_tick) begin
          nx = m_x; ny = m_y; ndx = m_dx; ndy = m_dy; missed = 0;
          if (m_dx == 0 && m_x < SPD)            begin nx = 0;    ndx = 1; end
          else if (m_dx == 1 && m_x + SPD > XMAX) begin nx = XMAX; ndx = 0; end
          else nx = (m_dx == 1) ? m_x + SPD : m_x - SPD;
          if (m_pend == 1)                        begin ndy = 0; ny = (m_y < SPD) ? 0 : m_y - SPD; end
          else if (m_dy == 0 && m_y < SPD)        begin ny = 0;  ndy = 1; end
          else if (m_dy == 1 && m_y + SPD > YMAX) missed = 1;
          else ny = (m_dy == 1) ? m_y + SPD : m_y - SPD;
          if (missed == 1) begin
            m_phase = 3; m_pulse = 1; m_wait = 0;
            if (m_misses < 15) m_misses++;
          end else begin
            m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
          end
          m_pend = 0;
        end
        if (toggled == 1) m_pend = 1;
      end
      default: begin
        m_pend = 0;
        if (frame_tick) m_wait++;
        if (m_wait == FRAMES) begin
          m_phase = 1; m_wait = 0; m_x = SX; m_y = SY; m_dx = 1; m_dy = 0;
        end
      end
    endcase
  endfunction

  // Continuous comparison of every output against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("per_cycle {x,y,dx,dy,state,pulse,count}",
            {3'b0, ball_x_reg, ball_y_reg, dir_x, dir_y, state, miss_pulse, miss_count},
            {3'b0, m_x[9:0], m_y[9:0], m_dx[0], m_dy[0], m_phase[1:0], m_pulse[0], m_misses[3:0]});
    end
  end

  // Stimulus sits just after a falling edge between calls.
  task automatic clk_cycle(input logic tick, input logic btn, input logic flip);
    frame_tick = tick;
    start_btn  = btn;
    if (flip) hit_toggle = ~hit_toggle;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_tick(input logic flip_before, input logic flip_with);
    clk_cycle(1'b0, 1'b0, flip_before);
    clk_cycle(1'b1, 1'b0, flip_with);
    tick_n++;
  endtask

  task automatic run_to(input int n);
    for (int i = 0; i < 20000 && tick_n < n; i++) do_tick(1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_x"}, 32'(ball_x_reg), 32'(SX));
    check({tag, "_y"}, 32'(ball_y_reg), 32'(SY));
    check({tag, "_dir_x"}, 32'(dir_x), 32'd1);
    check({tag, "_dir_y"}, 32'(dir_y), 32'd0);
    check({tag, "_miss_pulse"}, 32'(miss_pulse), 32'd0);
    check({tag, "_miss_count"}, 32'(miss_count), 32'd0);
  endtask

  // MOVE starts after the 60th tick following start_btn.
  function automatic int mv(input int k);
    return FRAMES + k;
  endfunction

  initial begin
    rst = 1'b1; frame_tick = 1'b0; start_btn = 1'b0; hit_toggle = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // IDLE ignores ticks and hit toggles.
    for (int i = 0; i < 5; i++) clk_cycle(1'b1, 1'b0, i == 2);
    check("idle_state", 32'(state), 32'd0);
    check("idle_x", 32'(ball_x_reg), 32'(SX));

    clk_cycle(1'b0, 1'b1, 1'b0);
    check("serve_entry", 32'(state), 32'd1);
    tick_n = 0;

    // Serve wait, with a discarded toggle partway through.
    for (int i = 1; i < FRAMES; i++) do_tick(i == 10, 1'b0);
    check("serve_59_still_serve", 32'(state), 32'd1);
    do_tick(1'b0, 1'b0);
    check("serve_60_move", 32'(state), 32'd2);
    check("serve_60_x", 32'(ball_x_reg), 32'd316);
    check("serve_60_y", 32'(ball_y_reg), 32'd236);

    do_tick(1'b0, 1'b0);
    check("first_move_x", 32'(ball_x_reg), 32'd318);
    check("first_move_y", 32'(ball_y_reg), 32'd234);

    run_to(mv(119));
    check("top_wall_y", 32'(ball_y_reg), 32'd0);
    check("top_wall_dir_y", 32'(dir_y), 32'd1);
    run_to(mv(120));
    check("top_wall_next_y", 32'(ball_y_reg), 32'd2);

    run_to(mv(159));
    check("right_wall_x", 32'(ball_x_reg), 32'd632);
    check("right_wall_dir_x", 32'(dir_x), 32'd0);
    run_to(mv(160));
    check("right_wall_next_x", 32'(ball_x_reg), 32'd630);

    run_to(mv(319));
    check("pre_hit_y", 32'(ball_y_reg), 32'd400);
    do_tick(1'b1, 1'b0);
    check("hit_y", 32'(ball_y_reg), 32'd398);
    check("hit_dir_y", 32'(dir_y), 32'd0);

    run_to(mv(476));
    check("left_wall_x", 32'(ball_x_reg), 32'd0);
    check("left_wall_dir_x", 32'(dir_x), 32'd1);
    run_to(mv(477));
    check("left_wall_next_x", 32'(ball_x_reg), 32'd2);

    // Toggle coincident with a tick is held over; it then beats the bottom.
    run_to(mv(755));
    check("pre_bottom_y", 32'(ball_y_reg), 32'd470);
    do_tick(1'b0, 1'b1);
    check("late_hit_y", 32'(ball_y_reg), 32'd472);
    check("late_hit_dir_y", 32'(dir_y), 32'd1);
    do_tick(1'b0, 1'b0);
    check("hit_beats_miss_state", 32'(state), 32'd2);
    check("hit_beats_miss_y", 32'(ball_y_reg), 32'd470);
    check("hit_beats_miss_dir_y", 32'(dir_y), 32'd0);

    run_to(mv(1229));
    do_tick(1'b0, 1'b0);
    check("miss_state", 32'(state), 32'd3);
    check("miss_pulse_high", 32'(miss_pulse), 32'd1);
    check("miss_count_1", 32'(miss_count), 32'd1);
    check("miss_frozen_y", 32'(ball_y_reg), 32'd472);
    clk_cycle(1'b0, 1'b0, 1'b1);
    check("miss_pulse_low", 32'(miss_pulse), 32'd0);

    run_to(mv(1290));
    check("reserve_state", 32'(state), 32'd1);
    check("reserve_x", 32'(ball_x_reg), 32'd316);
    check("reserve_y", 32'(ball_y_reg), 32'd236);
    check("reserve_count", 32'(miss_count), 32'd1);

    // Fifteen more unassisted rallies, 476 ticks each: the last one saturates.
    run_to(mv(1230 + 15 * 476));
    check("sat_state", 32'(state), 32'd3);
    check("sat_pulse", 32'(miss_pulse), 32'd1);
    check("sat_count", 32'(miss_count), 32'd15);

    run_to(mv(1230 + 15 * 476 + 125));
    check("pre_reset_move", 32'(state), 32'd2);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_values("mid_reset");
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) clk_cycle(1'b1, 1'b0, 1'b0);
    check("post_reset_idle", 32'(state), 32'd0);
    check("post_reset_count", 32'(miss_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
